// File: rtl/l2_types.sv
// Shared L2 type definitions: arbiter state encoding, line geometry, address helper.
package l2_types;

   localparam int unsigned LINE_WIDTH = 256;
   localparam int unsigned EWB_TAG_W  = 27;
   localparam int unsigned ADDR_W     = 32;

   // Eviction write-back arbiter states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_MEM_RD = 3'd2,
      ST_ENQ    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_RESP   = 3'd5
   } ewb_arb_state_t;

   // Cacheline-aligned address: byte offset bits [4:0] forced to zero.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(32'h1F);
   endfunction

endpackage

// File: rtl/ewb_mem_arbiter.sv
// Eviction write-back buffer sequencer and pmem port arbiter between L2 fills and EWB drains.
module ewb_mem_arbiter
   import l2_types::*;
#(
   parameter int unsigned WIDTH      = LINE_WIDTH,
   parameter int unsigned TAG_W      = EWB_TAG_W,
   parameter int unsigned IDLE_DELAY = 4
) (
   input  logic               clk,
   input  logic               rst,
   // L2 controller side
   input  logic               l2_read,
   input  logic               l2_write,
   input  logic [31:0]        l2_address,
   input  logic [WIDTH-1:0]   l2_wdata,
   output logic [WIDTH-1:0]   l2_rdata,
   output logic               l2_resp,
   // EWB enqueue
   output logic               ewb_valid,
   output logic [WIDTH-1:0]   ewb_wdata,
   output logic [31:0]        ewb_waddr,
   input  logic               ewb_full,
   // EWB associative lookup / in-place replace
   output logic               ewb_tag_check,
   output logic [TAG_W-1:0]   ewb_tag,
   input  logic               ewb_hit,
   input  logic [WIDTH-1:0]   ewb_rdata,
   output logic               ewb_write,
   output logic [WIDTH-1:0]   ewb_replace,
   // EWB dequeue
   input  logic               ewb_empty,
   input  logic [WIDTH-1:0]   ewb_head_data,
   input  logic [31:0]        ewb_head_addr,
   output logic               ewb_yumi,
   // Physical memory port
   output logic               pmem_read,
   output logic               pmem_write,
   output logic [31:0]        pmem_address,
   output logic [WIDTH-1:0]   pmem_wdata,
   input  logic [WIDTH-1:0]   pmem_rdata,
   input  logic               pmem_resp
);

   localparam int unsigned CNT_W = (IDLE_DELAY > 1) ? $clog2(IDLE_DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_DELAY - 1);

   ewb_arb_state_t     r_state;
   ewb_arb_state_t     w_next_state;
   logic [CNT_W-1:0]   r_idle_cnt;
   logic [CNT_W-1:0]   w_idle_cnt_next;
   logic               r_forced;
   logic               w_forced_next;
   logic [WIDTH-1:0]   r_rdata;
   logic [WIDTH-1:0]   w_rdata_next;
   logic               w_l2_req;

   assign w_l2_req = l2_read | l2_write;

   // State, idle counter, forced-drain flag and fill-data holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_idle_cnt <= '0;
         r_forced   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state    <= w_next_state;
         r_idle_cnt <= w_idle_cnt_next;
         r_forced   <= w_forced_next;
         r_rdata    <= w_rdata_next;
      end
   end

   // Next-state and output decode; every output is zero outside the state that owns it.
   always_comb begin
      w_next_state    = r_state;
      w_idle_cnt_next = '0;
      w_forced_next   = r_forced;
      w_rdata_next    = r_rdata;

      l2_rdata        = '0;
      l2_resp         = 1'b0;
      ewb_valid       = 1'b0;
      ewb_wdata       = '0;
      ewb_waddr       = '0;
      ewb_tag_check   = 1'b0;
      ewb_tag         = '0;
      ewb_write       = 1'b0;
      ewb_replace     = '0;
      ewb_yumi        = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      pmem_address    = '0;
      pmem_wdata      = '0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_l2_req) begin
               w_next_state = ST_CHECK;
            end else begin
               // Background drain only after IDLE_DELAY consecutive quiet cycles.
               if (!ewb_empty && (r_idle_cnt == CNT_MAX)) begin
                  w_next_state  = ST_DRAIN;
                  w_forced_next = 1'b0;
               end
               w_idle_cnt_next = (r_idle_cnt == CNT_MAX) ? r_idle_cnt
                                                         : r_idle_cnt + CNT_W'(1);
            end
         end

         ST_CHECK: begin
            ewb_tag_check = 1'b1;
            ewb_tag       = l2_address[31 -: TAG_W];
            ewb_write     = l2_write;
            ewb_replace   = l2_wdata;
            if (l2_read) begin
               // Queued line is newer than memory: serve the read from the EWB.
               if (ewb_hit) begin
                  w_rdata_next = ewb_rdata;
                  w_next_state = ST_RESP;
               end else begin
                  w_next_state = ST_MEM_RD;
               end
            end else if (l2_write) begin
               if (ewb_hit) begin
                  w_next_state = ST_RESP;
               end else if (!ewb_full) begin
                  w_next_state = ST_ENQ;
               end else begin
                  // Make room first, then re-run the lookup for this eviction.
                  w_next_state  = ST_DRAIN;
                  w_forced_next = 1'b1;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end

         ST_MEM_RD: begin
            pmem_read    = 1'b1;
            pmem_address = line_addr(l2_address);
            if (pmem_resp) begin
               w_rdata_next = pmem_rdata;
               w_next_state = ST_RESP;
            end
         end

         ST_ENQ: begin
            ewb_valid    = !ewb_full;
            ewb_wdata    = l2_wdata;
            ewb_waddr    = l2_address;
            w_next_state = ST_RESP;
         end

         ST_DRAIN: begin
            pmem_write   = 1'b1;
            pmem_address = line_addr(ewb_head_addr);
            pmem_wdata   = ewb_head_data;
            if (pmem_resp) begin
               ewb_yumi      = !ewb_empty;
               w_next_state  = r_forced ? ST_CHECK : ST_IDLE;
               w_forced_next = 1'b0;
            end
         end

         ST_RESP: begin
            l2_resp      = 1'b1;
            l2_rdata     = r_rdata;
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state  = ST_IDLE;
            w_forced_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ewb_mem_arbiter.sv
// Self-checking bench for ewb_mem_arbiter with behavioural EWB and pmem models.
module tb_ewb_mem_arbiter;
   import l2_types::*;

   localparam int unsigned W     = 256;
   localparam int          DEPTH = 4;
   localparam int          LAT   = 3;

   logic            clk;
   logic            rst;
   logic            l2_read, l2_write;
   logic [31:0]     l2_address;
   logic [W-1:0]    l2_wdata, l2_rdata;
   logic            l2_resp;
   logic            ewb_valid;
   logic [W-1:0]    ewb_wdata;
   logic [31:0]     ewb_waddr;
   logic            ewb_full;
   logic            ewb_tag_check;
   logic [26:0]     ewb_tag;
   logic            ewb_hit;
   logic [W-1:0]    ewb_rdata;
   logic            ewb_write;
   logic [W-1:0]    ewb_replace;
   logic            ewb_empty;
   logic [W-1:0]    ewb_head_data;
   logic [31:0]     ewb_head_addr;
   logic            ewb_yumi;
   logic            pmem_read, pmem_write;
   logic [31:0]     pmem_address;
   logic [W-1:0]    pmem_wdata, pmem_rdata;
   logic            pmem_resp;

   int tests = 0;
   int fails = 0;

   ewb_mem_arbiter #(.WIDTH(W), .TAG_W(27), .IDLE_DELAY(4)) dut (
      .clk(clk), .rst(rst),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
      .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
      .ewb_valid(ewb_valid), .ewb_wdata(ewb_wdata), .ewb_waddr(ewb_waddr),
      .ewb_full(ewb_full), .ewb_tag_check(ewb_tag_check), .ewb_tag(ewb_tag),
      .ewb_hit(ewb_hit), .ewb_rdata(ewb_rdata), .ewb_write(ewb_write),
      .ewb_replace(ewb_replace), .ewb_empty(ewb_empty),
      .ewb_head_data(ewb_head_data), .ewb_head_addr(ewb_head_addr),
      .ewb_yumi(ewb_yumi), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference memory content for a line.
   function automatic logic [W-1:0] mem_line(input logic [31:0] a);
      return {8{(a & ~32'h1F) ^ 32'hA5A5_0000}};
   endfunction

   // ---------------- EWB model ----------------
   logic [31:0]  q_addr [DEPTH];
   logic [W-1:0] q_data [DEPTH];
   int           q_cnt;

   always_comb begin
      ewb_full      = (q_cnt == DEPTH);
      ewb_empty     = (q_cnt == 0);
      ewb_head_addr = q_addr[0];
      ewb_head_data = q_data[0];
      ewb_hit       = 1'b0;
      ewb_rdata     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < q_cnt && ewb_tag_check && q_addr[i][31:5] == ewb_tag) begin
            ewb_hit   = 1'b1;
            ewb_rdata = q_data[i];
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_cnt <= 0;
      end else if (ewb_yumi && q_cnt > 0) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            q_addr[i] <= q_addr[i+1];
            q_data[i] <= q_data[i+1];
         end
         q_cnt <= q_cnt - 1;
      end else if (ewb_valid && q_cnt < DEPTH) begin
         q_addr[2'(q_cnt)] <= ewb_waddr;
         q_data[2'(q_cnt)] <= ewb_wdata;
         q_cnt <= q_cnt + 1;
      end else if (ewb_write && ewb_hit) begin
         for (int i = 0; i < DEPTH; i++)
            if (i < q_cnt && q_addr[i][31:5] == ewb_tag) q_data[i] <= ewb_replace;
      end
   end

   // ---------------- pmem model ----------------
   int           pcnt;
   int           rd_count, wr_count;
   logic [31:0]  last_rd_addr;
   logic [31:0]  wlog_addr [8];
   logic [W-1:0] wlog_data [8];

   assign pmem_rdata = mem_line(pmem_address);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pmem_resp    <= 1'b0;
         pcnt         <= 0;
         rd_count     <= 0;
         wr_count     <= 0;
         last_rd_addr <= '0;
      end else begin
         if (pmem_resp) begin
            pmem_resp <= 1'b0;
            pcnt      <= 0;
            if (pmem_read) begin
               rd_count     <= rd_count + 1;
               last_rd_addr <= pmem_address;
            end
            if (pmem_write) begin
               wlog_addr[3'(wr_count)] <= pmem_address;
               wlog_data[3'(wr_count)] <= pmem_wdata;
               wr_count <= wr_count + 1;
            end
         end else if (pmem_read || pmem_write) begin
            if (pcnt == LAT - 1) begin
               pmem_resp <= 1'b1;
               pcnt      <= 0;
            end else begin
               pcnt <= pcnt + 1;
            end
         end else begin
            pcnt <= 0;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   int   viol = 0, resp_count = 0, yumi_count = 0, rd_cycles = 0;
   logic prev_resp = 1'b0;

   always @(negedge clk) begin
      if ((ewb_valid && ewb_yumi) || (ewb_valid && ewb_tag_check) ||
          (pmem_read && pmem_write) || (ewb_valid && ewb_full) ||
          (ewb_yumi && ewb_empty) || (l2_resp && prev_resp))
         viol <= viol + 1;
      prev_resp <= l2_resp;
      if (l2_resp)   resp_count <= resp_count + 1;
      if (ewb_yumi)  yumi_count <= yumi_count + 1;
      if (pmem_read) rd_cycles  <= rd_cycles + 1;
   end

   logic any_out;
   assign any_out = |{l2_rdata, l2_resp, ewb_valid, ewb_wdata, ewb_waddr, ewb_tag_check,
                      ewb_tag, ewb_write, ewb_replace, ewb_yumi, pmem_read, pmem_write,
                      pmem_address, pmem_wdata};

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      l2_read = 1'b0; l2_write = 1'b0; l2_address = '0; l2_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One L2 request; lat counts request cycle through resp cycle inclusive.
   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [W-1:0] data,
                         output logic [W-1:0] rdata, output logic ok, output int lat);
      @(negedge clk);
      l2_read = !wr; l2_write = wr; l2_address = addr; l2_wdata = data;
      ok = 1'b0; rdata = '0; lat = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (l2_resp) begin
            ok = 1'b1; rdata = l2_rdata; lat = c + 2;
            break;
         end
      end
      l2_read = 1'b0; l2_write = 1'b0;
   endtask

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [W-1:0] wdata;
      logic [W-1:0] exp_rdata;
      int           exp_lat;
      int           exp_rd;
      int           exp_cnt;
   } vec_t;

   vec_t vecs [8];

   localparam logic [W-1:0] DA  = {8{32'hAAAA_2000}};
   localparam logic [W-1:0] DA3 = {8{32'hA3A3_3000}};
   localparam logic [W-1:0] DB3 = {8{32'hB3B3_3000}};
   localparam logic [W-1:0] DW  = {8{32'h5757_4000}};

   initial begin
      logic [W-1:0] rd;
      logic         ok;
      int           lat, idle, r0, y0;
      string        nm;

      vecs[0] = '{1'b0, 32'h0000_1040, '0,  mem_line(32'h1040), 7, 1, 0};
      vecs[1] = '{1'b1, 32'h0000_2000, DA,  '0,                 4, 1, 1};
      vecs[2] = '{1'b0, 32'h0000_2000, '0,  DA,                 3, 1, 1};
      vecs[3] = '{1'b1, 32'h0000_3000, DA3, '0,                 4, 1, 2};
      vecs[4] = '{1'b1, 32'h0000_3000, DB3, '0,                 3, 1, 2};
      vecs[5] = '{1'b0, 32'h0000_3010, '0,  DB3,                3, 1, 2};
      vecs[6] = '{1'b0, 32'h0000_5000, '0,  mem_line(32'h5000), 7, 2, 2};
      vecs[7] = '{1'b0, 32'h0000_2004, '0,  DA,                 3, 2, 2};

      rst = 1'b1;
      l2_read = 1'b0; l2_write = 1'b0; l2_address = '0; l2_wdata = '0;
      #2;
      check("reset_outputs", W'(any_out), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table: misses, evictions, merges and EWB-hit reads.
      for (int v = 0; v < 8; v++) begin
         r0 = rd_count;
         do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, ok, lat);
         nm = $sformatf("v%0d", v);
         check({nm, "_resp"}, W'(ok), W'(1));
         check({nm, "_lat"}, W'(lat), W'(vecs[v].exp_lat));
         check({nm, "_pmem_reads"}, W'(rd_count), W'(vecs[v].exp_rd));
         check({nm, "_ewb_cnt"}, W'(q_cnt), W'(vecs[v].exp_cnt));
         if (!vecs[v].wr) check({nm, "_rdata"}, rd, vecs[v].exp_rdata);
         if (rd_count != r0)
            check({nm, "_rd_addr"}, W'(last_rd_addr), W'(vecs[v].addr & ~32'h1F));
      end

      // Background drain after four idle cycles; a read arriving mid-drain waits.
      idle = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pmem_write) break;
         idle++;
      end
      check("bg_idle_cycles", W'(idle), W'(4));
      check("bg_drain_addr", W'(pmem_address), W'(32'h2000));
      check("bg_drain_data", pmem_wdata, DA);
      r0 = rd_count; y0 = yumi_count;
      l2_read = 1'b1; l2_address = 32'h0000_3000;
      ok = 1'b0; rd = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (l2_resp) begin
            ok = 1'b1; rd = l2_rdata;
            check("mid_drain_wr_done", W'(wr_count), W'(1));
            check("mid_drain_yumi", W'(yumi_count - y0), W'(1));
            break;
         end
      end
      l2_read = 1'b0;
      check("mid_drain_resp", W'(ok), W'(1));
      check("mid_drain_rdata", rd, DB3);
      check("mid_drain_no_pmem_rd", W'(rd_count - r0), W'(0));
      check("bg_log0_addr", W'(wlog_addr[0]), W'(32'h2000));
      for (int c = 0; c < 40 && wr_count < 2; c++) @(negedge clk);
      check("bg_second_drain", W'(wr_count), W'(2));
      check("merge_drain_addr", W'(wlog_addr[1]), W'(32'h3000));
      check("merge_drain_data", wlog_data[1], DB3);
      check("ewb_drained", W'(q_cnt), W'(0));

      // Full EWB: forced drain of the head, then enqueue of the new eviction.
      do_reset();
      for (int i = 0; i < 4; i++)
         do_req(1'b1, 32'h0001_0000 + 32'(i) * 32'h1000, {8{32'h0D00_0000 + 32'(i)}}, rd, ok, lat);
      check("fill_cnt", W'(q_cnt), W'(4));
      check("fill_no_drain", W'(wr_count), W'(0));
      y0 = yumi_count;
      do_req(1'b1, 32'h0000_4000, DW, rd, ok, lat);
      check("full_resp", W'(ok), W'(1));
      check("full_drains", W'(wr_count), W'(1));
      check("full_drain_addr", W'(wlog_addr[0]), W'(32'h0001_0000));
      check("full_drain_data", wlog_data[0], {8{32'h0D00_0000}});
      check("full_yumi", W'(yumi_count - y0), W'(1));
      check("full_cnt_after", W'(q_cnt), W'(4));
      check("full_tail_addr", W'(q_addr[3]), W'(32'h4000));
      check("full_tail_data", q_data[3], DW);
      check("full_no_pmem_rd", W'(rd_count), W'(0));

      // Async reset in the middle of a memory read.
      do_reset();
      @(negedge clk);
      l2_read = 1'b1; l2_address = 32'h0000_7000;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pmem_read) begin ok = 1'b1; break; end
      end
      check("rst_saw_pmem_read", W'(ok), W'(1));
      rst = 1'b1; l2_read = 1'b0;
      #1;
      check("rst_outputs_now", W'(any_out), W'(0));
      @(negedge clk);
      rst = 1'b0;
      r0 = resp_count;
      repeat (10) @(negedge clk);
      check("rst_no_resp", W'(resp_count - r0), W'(0));
      check("rst_idle_outputs", W'(any_out), W'(0));
      check("rst_no_pmem_rd_done", W'(rd_count), W'(0));

      check("protocol_invariants", W'(viol), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
